i2c_request_arbiter: RTL and testbench

Shares the single I2C transaction engine between up to NREQ hardware requesters. The engine is the PicoBlaze-based open-drain master with execute/address/numbytes/data/result registers. The block grants one requester at a time with round-robin fairness and presents the latched transaction to the engine. It waits for completion or timeout, then returns the result and read data to the granted requester. It sits between board-level clients (monitors, config loaders) and the engine register interface.

---
 rtl/i2c_arb_pkg.sv | 18 +
 rtl/i2c_request_arbiter_if.sv | 44 ++++
 rtl/i2c_request_arbiter_rr_pick.sv | 32 +++
 rtl/i2c_request_arbiter.sv | 157 +++++++++++++++
 tb/tb_i2c_request_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_arb_pkg;

   // Arbiter control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // Completion codes returned to requesters; RES_TIMEOUT is produced only by the arbiter
   localparam logic [1:0] RES_OK        = 2'd0;
   localparam logic [1:0] RES_NACK_ADDR = 2'd1;
   localparam logic [1:0] RES_NACK_DATA = 2'd2;
   localparam logic [1:0] RES_TIMEOUT   = 2'd3;

endpackage

// File: rtl/i2c_request_arbiter_if.sv
// Requester and engine-register signal bundle for the I2C request arbiter.
interface i2c_request_arbiter_if #(
   parameter int NREQ = 4
);
   // requester side
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_rw;
   logic [7*NREQ-1:0]    req_addr;
   logic [2*NREQ-1:0]    req_numbytes;
   logic [32*NREQ-1:0]   req_wdata;
   logic [NREQ-1:0]      rsp_valid;
   logic [1:0]           rsp_result;
   logic [31:0]          rsp_rdata;
   logic                 busy;

   // engine side
   logic                 eng_execute;
   logic                 eng_rw;
   logic [6:0]           eng_address;
   logic [1:0]           eng_numbytes;
   logic [31:0]          eng_wdata;
   logic                 eng_done;
   logic [1:0]           eng_result;
   logic [31:0]          eng_rdata;
   logic                 eng_abort;

   // arbiter view
   modport slave (
      input  req_valid, req_rw, req_addr, req_numbytes, req_wdata,
      input  eng_done, eng_result, eng_rdata,
      output req_ready, rsp_valid, rsp_result, rsp_rdata, busy,
      output eng_execute, eng_rw, eng_address, eng_numbytes, eng_wdata, eng_abort
   );

   // requesters plus engine view
   modport master (
      output req_valid, req_rw, req_addr, req_numbytes, req_wdata,
      output eng_done, eng_result, eng_rdata,
      input  req_ready, rsp_valid, rsp_result, rsp_rdata, busy,
      input  eng_execute, eng_rw, eng_address, eng_numbytes, eng_wdata, eng_abort
   );

endinterface

// File: rtl/i2c_request_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request at or above ptr, wrapping modulo NREQ.
module i2c_rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            found,
   output logic [IW-1:0]   index
);

   // (base + off) mod NREQ, valid for base < NREQ and off < NREQ
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      return IW'(sum);
   endfunction

   // Scan from the farthest offset down so the closest request to ptr is the last written
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) begin
            found = 1'b1;
            index = wrap_add(ptr, k);
         end
      end
   end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter sharing one I2C transaction engine among NREQ requesters.
// Latches the winning request into the engine registers, waits for completion or
// timeout, and returns the result to the granted requester.
module i2c_request_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                reset_n,
   i2c_request_arbiter_if.slave bus
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] LAST_REQ   = IW'(NREQ - 1);

   arb_state_t         state;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      grant;
   logic [CW-1:0]      count;

   logic               pick_found;
   logic [IW-1:0]      pick_index;

   // per-requester views of the packed request fields
   logic               rw_arr   [NREQ];
   logic [6:0]         addr_arr [NREQ];
   logic [1:0]         nb_arr   [NREQ];
   logic [31:0]        wd_arr   [NREQ];

   // registered outputs
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [1:0]         rsp_result;
   logic [31:0]        rsp_rdata;
   logic               busy;
   logic               eng_execute;
   logic               eng_abort;
   logic               eng_rw;
   logic [6:0]         eng_address;
   logic [1:0]         eng_numbytes;
   logic [31:0]        eng_wdata;

   i2c_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .found (pick_found),
      .index (pick_index)
   );

   // Split the packed request fields into per-requester slices
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         rw_arr[i]   = bus.req_rw[i];
         addr_arr[i] = bus.req_addr[7*i +: 7];
         nb_arr[i]   = bus.req_numbytes[2*i +: 2];
         wd_arr[i]   = bus.req_wdata[32*i +: 32];
      end
   end

   // Control FSM, timeout counter and engine/response field registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         grant        <= '0;
         count        <= '0;
         req_ready    <= '0;
         rsp_valid    <= '0;
         rsp_result   <= RES_OK;
         rsp_rdata    <= '0;
         busy         <= 1'b0;
         eng_execute  <= 1'b0;
         eng_abort    <= 1'b0;
         eng_rw       <= 1'b0;
         eng_address  <= '0;
         eng_numbytes <= '0;
         eng_wdata    <= '0;
      end else begin
         // single-cycle pulses default low
         req_ready   <= '0;
         rsp_valid   <= '0;
         eng_execute <= 1'b0;
         eng_abort   <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant        <= pick_index;
                  eng_rw       <= rw_arr[pick_index];
                  eng_address  <= addr_arr[pick_index];
                  eng_numbytes <= nb_arr[pick_index];
                  eng_wdata    <= wd_arr[pick_index];
                  req_ready    <= NREQ'(1) << pick_index;
                  // start pulse lines up with the ISSUE cycle
                  eng_execute  <= 1'b1;
                  busy         <= 1'b1;
                  state        <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               count <= '0;
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               // completion beats a simultaneous timeout
               if (bus.eng_done) begin
                  rsp_result <= bus.eng_result;
                  rsp_rdata  <= bus.eng_rdata;
                  rsp_valid  <= NREQ'(1) << grant;
                  state      <= ST_RESP;
               end else if (count == LAST_COUNT) begin
                  rsp_result <= RES_TIMEOUT;
                  rsp_rdata  <= '0;
                  eng_abort  <= 1'b1;
                  rsp_valid  <= NREQ'(1) << grant;
                  state      <= ST_RESP;
               end else begin
                  count <= count + CW'(1);
               end
            end

            ST_RESP: begin
               ptr   <= (grant == LAST_REQ) ? '0 : grant + IW'(1);
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = req_ready;
   assign bus.rsp_valid    = rsp_valid;
   assign bus.rsp_result   = rsp_result;
   assign bus.rsp_rdata    = rsp_rdata;
   assign bus.busy         = busy;
   assign bus.eng_execute  = eng_execute;
   assign bus.eng_abort    = eng_abort;
   assign bus.eng_rw       = eng_rw;
   assign bus.eng_address  = eng_address;
   assign bus.eng_numbytes = eng_numbytes;
   assign bus.eng_wdata    = eng_wdata;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Directed testbench for i2c_request_arbiter (NREQ=4, TIMEOUT_CYCLES=16).
module tb_i2c_request_arbiter;
   import i2c_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int TO   = 16;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   i2c_request_arbiter_if #(.NREQ(NREQ)) bus ();

   i2c_request_arbiter #(
      .NREQ           (NREQ),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // inputs change and outputs are observed on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic rw, input logic [6:0] a,
                          input logic [1:0] nb, input logic [31:0] wd);
      bus.req_rw[i]              = rw;
      bus.req_addr[7*i +: 7]     = a;
      bus.req_numbytes[2*i +: 2] = nb;
      bus.req_wdata[32*i +: 32]  = wd;
   endtask

   task automatic engine_done(input logic [1:0] res, input logic [31:0] rd);
      bus.eng_done   = 1'b1;
      bus.eng_result = res;
      bus.eng_rdata  = rd;
   endtask

   // wait up to 20 cycles for a grant; ok=0 when none arrived
   task automatic wait_grant(output logic [NREQ-1:0] rdy, output bit ok);
      ok  = 1'b0;
      rdy = '0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.req_ready != '0) begin
            rdy = bus.req_ready;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", bus.rsp_valid); end
      checks++; if ({bus.eng_execute, bus.eng_abort} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {bus.eng_execute, bus.eng_abort}); end
      checks++; if ({bus.eng_rw, bus.eng_address, bus.eng_numbytes, bus.eng_wdata} !== 42'd0) begin errors++; $display("FAIL reset_eng_fields got %h exp 0", {bus.eng_rw, bus.eng_address, bus.eng_numbytes, bus.eng_wdata}); end
      checks++; if ({bus.rsp_result, bus.rsp_rdata} !== 34'd0) begin errors++; $display("FAIL reset_rsp_fields got %h exp 0", {bus.rsp_result, bus.rsp_rdata}); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_req(2, 1'b1, 7'h48, 2'd1, 32'h0);
      bus.req_valid = 4'b0100;
      tick();
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", bus.req_ready); end
      checks++; if (bus.eng_execute !== 1'b1) begin errors++; $display("FAIL single_execute got %b exp 1", bus.eng_execute); end
      checks++; if ({bus.eng_rw, bus.eng_address, bus.eng_numbytes} !== {1'b1, 7'h48, 2'd1}) begin errors++; $display("FAIL single_fields got %b/%h/%0d exp 1/48/1", bus.eng_rw, bus.eng_address, bus.eng_numbytes); end
      bus.req_valid = 4'b0000;
      tick();
      checks++; if (bus.eng_execute !== 1'b0) begin errors++; $display("FAIL single_execute_width got %b exp 0", bus.eng_execute); end
      engine_done(RES_OK, 32'h0000BEEF);
      tick();
      bus.eng_done = 1'b0;
      checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b exp 0100", bus.rsp_valid); end
      checks++; if ({bus.rsp_result, bus.rsp_rdata} !== {2'd0, 32'h0000BEEF}) begin errors++; $display("FAIL single_rsp got %0d/%h exp 0/0000beef", bus.rsp_result, bus.rsp_rdata); end
      tick();
      checks++; if ({bus.rsp_valid, bus.busy} !== 5'b0) begin errors++; $display("FAIL single_after got %b/%b exp 0000/0", bus.rsp_valid, bus.busy); end
      checks++; if (bus.rsp_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL single_rdata_held got %h exp 0000beef", bus.rsp_rdata); end
   endtask

   task automatic test_back_to_back();
      set_req(0, 1'b0, 7'h01, 2'd0, 32'h11);
      set_req(1, 1'b0, 7'h02, 2'd0, 32'h22);
      bus.req_valid = 4'b0011;
      tick();
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_first_grant got %b exp 0001", bus.req_ready); end
      bus.req_valid = 4'b0010;
      tick();
      engine_done(RES_OK, 32'h1);
      tick();
      bus.eng_done = 1'b0;
      checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL b2b_first_rsp got %b exp 0001", bus.rsp_valid); end
      tick();
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL b2b_idle_gap got %b exp 0000", bus.req_ready); end
      tick();
      checks++; if ({bus.req_ready, bus.eng_execute, bus.eng_address} !== {4'b0010, 1'b1, 7'h02}) begin errors++; $display("FAIL b2b_second_grant got %b/%b/%h exp 0010/1/02", bus.req_ready, bus.eng_execute, bus.eng_address); end
      bus.req_valid = 4'b0000;
      tick();
      engine_done(RES_NACK_ADDR, 32'h2);
      tick();
      bus.eng_done = 1'b0;
      checks++; if ({bus.rsp_valid, bus.rsp_result} !== {4'b0010, 2'd1}) begin errors++; $display("FAIL b2b_second_rsp got %b/%0d exp 0010/1", bus.rsp_valid, bus.rsp_result); end
      tick();
   endtask

   task automatic test_round_robin();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      logic [NREQ-1:0] rdy;
      bit ok;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 7'(7'h10 + i), 2'(i), 32'h0);
      bus.req_valid = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         wait_grant(rdy, ok);
         checks++; if (!ok || rdy !== (4'b0001 << exp_order[t])) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", t, rdy, 4'b0001 << exp_order[t]); end
         checks++; if (bus.eng_address !== 7'(7'h10 + exp_order[t])) begin errors++; $display("FAIL rr_addr_%0d got %h exp %h", t, bus.eng_address, 7'(7'h10 + exp_order[t])); end
         if (t == 4) bus.req_valid = 4'b0000;
         repeat (5) tick();
         engine_done(RES_OK, 32'hA0 + t);
         tick();
         bus.eng_done = 1'b0;
         checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {4'b0001 << exp_order[t], 32'hA0 + t}) begin errors++; $display("FAIL rr_rsp_%0d got %b/%h exp %b/%h", t, bus.rsp_valid, bus.rsp_rdata, 4'b0001 << exp_order[t], 32'hA0 + t); end
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [NREQ-1:0] rdy;
      bit ok;
      bit early;
      set_req(1, 1'b0, 7'h22, 2'd3, 32'hCAFEF00D);
      bus.req_valid = 4'b0010;
      wait_grant(rdy, ok);
      checks++; if (!ok || rdy !== 4'b0010 || bus.eng_execute !== 1'b1 || bus.eng_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL to_grant got %b/%b/%h exp 0010/1/cafef00d", rdy, bus.eng_execute, bus.eng_wdata); end
      bus.req_valid = 4'b0000;
      early = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (bus.eng_abort !== 1'b0 || bus.rsp_valid !== 4'b0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL to_early got abort/rsp before execute+17 exp none"); end
      tick();
      checks++; if ({bus.eng_abort, bus.rsp_valid} !== 5'b1_0010) begin errors++; $display("FAIL to_abort got %b/%b exp 1/0010", bus.eng_abort, bus.rsp_valid); end
      checks++; if ({bus.rsp_result, bus.rsp_rdata} !== {2'd3, 32'h0}) begin errors++; $display("FAIL to_result got %0d/%h exp 3/00000000", bus.rsp_result, bus.rsp_rdata); end
      tick();
      checks++; if ({bus.eng_abort, bus.busy} !== 2'b00) begin errors++; $display("FAIL to_after got %b/%b exp 0/0", bus.eng_abort, bus.busy); end
   endtask

   task automatic test_done_at_limit();
      logic [NREQ-1:0] rdy;
      bit ok;
      set_req(3, 1'b1, 7'h33, 2'd2, 32'h0);
      bus.req_valid = 4'b1000;
      wait_grant(rdy, ok);
      checks++; if (!ok || rdy !== 4'b1000) begin errors++; $display("FAIL lim_grant got %b exp 1000", rdy); end
      bus.req_valid = 4'b0000;
      repeat (TO) tick();
      checks++; if ({bus.eng_abort, bus.rsp_valid} !== 5'b0) begin errors++; $display("FAIL lim_early got %b/%b exp 0/0000", bus.eng_abort, bus.rsp_valid); end
      engine_done(RES_NACK_DATA, 32'h12345678);
      tick();
      bus.eng_done = 1'b0;
      checks++; if ({bus.eng_abort, bus.rsp_valid} !== 5'b0_1000) begin errors++; $display("FAIL lim_rsp got %b/%b exp 0/1000", bus.eng_abort, bus.rsp_valid); end
      checks++; if ({bus.rsp_result, bus.rsp_rdata} !== {2'd2, 32'h12345678}) begin errors++; $display("FAIL lim_result got %0d/%h exp 2/12345678", bus.rsp_result, bus.rsp_rdata); end
      tick();
   endtask

   task automatic test_reset_in_wait();
      logic [NREQ-1:0] rdy;
      bit ok;
      set_req(0, 1'b1, 7'h5A, 2'd3, 32'h0);
      bus.req_valid = 4'b0001;
      wait_grant(rdy, ok);
      checks++; if (!ok || rdy !== 4'b0001) begin errors++; $display("FAIL rst_grant got %b exp 0001", rdy); end
      bus.req_valid = 4'b0000;
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      checks++; if ({bus.busy, bus.rsp_valid, bus.eng_abort, bus.eng_execute} !== 7'b0) begin errors++; $display("FAIL rst_ctrl got %b/%b/%b/%b exp 0", bus.busy, bus.rsp_valid, bus.eng_abort, bus.eng_execute); end
      checks++; if ({bus.eng_rw, bus.eng_address, bus.eng_numbytes, bus.rsp_result, bus.rsp_rdata} !== 44'd0) begin errors++; $display("FAIL rst_fields got %h exp 0", {bus.eng_rw, bus.eng_address, bus.eng_numbytes, bus.rsp_result, bus.rsp_rdata}); end
      reset_n = 1'b1;
      tick();
      engine_done(RES_NACK_ADDR, 32'hFFFF_FFFF);
      tick();
      bus.eng_done = 1'b0;
      checks++; if ({bus.rsp_valid, bus.busy, bus.rsp_result} !== 7'b0) begin errors++; $display("FAIL stray_done got %b/%b/%0d exp 0000/0/0", bus.rsp_valid, bus.busy, bus.rsp_result); end
      tick();
      checks++; if ({bus.rsp_valid, bus.busy, bus.rsp_rdata} !== 37'd0) begin errors++; $display("FAIL stray_done_late got %b/%b/%h exp 0000/0/0", bus.rsp_valid, bus.busy, bus.rsp_rdata); end
   endtask

   initial begin
      reset_n          = 1'b0;
      bus.req_valid    = '0;
      bus.req_rw       = '0;
      bus.req_addr     = '0;
      bus.req_numbytes = '0;
      bus.req_wdata    = '0;
      bus.eng_done     = 1'b0;
      bus.eng_result   = '0;
      bus.eng_rdata    = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_round_robin();
      test_timeout();
      test_done_at_limit();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
